// File: rtl/disparo_jugador.sv
// rtl/disparo_jugador.sv - Battleship attack stage: shot cursor, hit/miss marking, sink and victory tracking
module disparo_jugador #(
   parameter int N_CELDAS = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_disparo,
   input  logic                  nuevo_juego,
   input  logic                  izquierda,
   input  logic                  arriba,
   input  logic                  abajo,
   input  logic                  derecha,
   input  logic                  disparar,
   input  logic [4:0][4:0][3:0]  matriz_enemigo,
   output logic [4:0][4:0][3:0]  matriz_disparos,
   output logic [2:0]            posicion_x,
   output logic [2:0]            posicion_y,
   output logic                  acierto,
   output logic                  fallo,
   output logic                  hundido,
   output logic [2:0]            barco_hundido,
   output logic                  fin_turno,
   output logic                  victoria
);

   typedef enum logic [2:0] {IDLE, CARGA, APUNTAR, EVAL, GANADO} estado_t;

   localparam logic [3:0] META = 4'(N_CELDAS);

   estado_t              estado, estado_sig;
   logic                 cargado;
   logic [4:0][4:0][3:0] tablero;
   logic [2:0]           obj_x, obj_y;
   logic [4:0][2:0]      golpes;
   logic [3:0]           total;

   logic [3:0] valor;
   logic [2:0] id_barco, idx;
   logic       es_barco, hunde, gana, celda_libre, pausa;

   // Board values 6..15 fall outside 1..5 and are evaluated as water.
   assign valor       = tablero[obj_y][obj_x];
   assign es_barco    = (valor >= 4'd1) && (valor <= 4'd5);
   assign id_barco    = valor[2:0];
   assign idx         = id_barco - 3'd1;
   assign hunde       = (golpes[idx] + 3'd1) == id_barco;
   assign gana        = (total + 4'd1) == META;
   assign celda_libre = matriz_disparos[posicion_y][posicion_x] == 4'd0;
   assign pausa       = (estado != GANADO) && !en_disparo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) estado <= IDLE;
      else        estado <= estado_sig;
   end

   always_comb begin
      estado_sig = estado;
      if (nuevo_juego) begin
         estado_sig = IDLE;
      end else if (pausa) begin
         estado_sig = IDLE;
      end else begin
         case (estado)
            IDLE:    estado_sig = cargado ? APUNTAR : CARGA;
            CARGA:   estado_sig = APUNTAR;
            APUNTAR: if (disparar && celda_libre) estado_sig = EVAL;
            EVAL:    estado_sig = (es_barco && gana) ? GANADO : APUNTAR;
            GANADO:  estado_sig = GANADO;
            default: estado_sig = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cargado         <= 1'b0;
         tablero         <= '0;
         matriz_disparos <= '0;
         obj_x           <= '0;
         obj_y           <= '0;
         golpes          <= '0;
         total           <= '0;
         posicion_x      <= 3'd4;
         posicion_y      <= 3'd4;
         acierto         <= 1'b0;
         fallo           <= 1'b0;
         hundido         <= 1'b0;
         fin_turno       <= 1'b0;
         barco_hundido   <= '0;
         victoria        <= 1'b0;
      end else begin
         acierto   <= 1'b0;
         fallo     <= 1'b0;
         hundido   <= 1'b0;
         fin_turno <= 1'b0;
         if (nuevo_juego) begin
            cargado         <= 1'b0;
            matriz_disparos <= '0;
            golpes          <= '0;
            total           <= '0;
            posicion_x      <= 3'd4;
            posicion_y      <= 3'd4;
            barco_hundido   <= '0;
            victoria        <= 1'b0;
         end else if (!pausa) begin
            case (estado)
               CARGA: begin
                  tablero <= matriz_enemigo;
                  cargado <= 1'b1;
               end
               APUNTAR: begin
                  // A fire pulse swallows any move in the same cycle, even if the shot is refused.
                  if (disparar) begin
                     if (celda_libre) begin
                        obj_x <= posicion_x;
                        obj_y <= posicion_y;
                     end
                  end else begin
                     if (arriba && !abajo && posicion_y != 3'd4)     posicion_y <= posicion_y + 3'd1;
                     if (abajo && !arriba && posicion_y != 3'd0)     posicion_y <= posicion_y - 3'd1;
                     if (izquierda && !derecha && posicion_x != 3'd4) posicion_x <= posicion_x + 3'd1;
                     if (derecha && !izquierda && posicion_x != 3'd0) posicion_x <= posicion_x - 3'd1;
                  end
               end
               EVAL: begin
                  if (es_barco) begin
                     matriz_disparos[obj_y][obj_x] <= 4'd9;
                     acierto     <= 1'b1;
                     golpes[idx] <= golpes[idx] + 3'd1;
                     total       <= total + 4'd1;
                     if (hunde) begin
                        hundido       <= 1'b1;
                        barco_hundido <= id_barco;
                     end
                     if (gana) victoria <= 1'b1;
                  end else begin
                     matriz_disparos[obj_y][obj_x] <= 4'd8;
                     fallo     <= 1'b1;
                     fin_turno <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_disparo_jugador.sv
// tb/tb_disparo_jugador.sv - scoreboard bench for disparo_jugador
module tb_disparo_jugador;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 en_disparo = 1'b0;
   logic                 nuevo_juego = 1'b0;
   logic                 izquierda = 1'b0, arriba = 1'b0, abajo = 1'b0, derecha = 1'b0;
   logic                 disparar = 1'b0;
   logic [4:0][4:0][3:0] matriz_enemigo = '0;
   logic [4:0][4:0][3:0] matriz_disparos;
   logic [2:0]           posicion_x, posicion_y;
   logic                 acierto, fallo, hundido, fin_turno, victoria;
   logic [2:0]           barco_hundido;

   disparo_jugador #(.N_CELDAS(15)) dut (
      .clk(clk), .rst_n(rst_n), .en_disparo(en_disparo), .nuevo_juego(nuevo_juego),
      .izquierda(izquierda), .arriba(arriba), .abajo(abajo), .derecha(derecha),
      .disparar(disparar), .matriz_enemigo(matriz_enemigo), .matriz_disparos(matriz_disparos),
      .posicion_x(posicion_x), .posicion_y(posicion_y), .acierto(acierto), .fallo(fallo),
      .hundido(hundido), .barco_hundido(barco_hundido), .fin_turno(fin_turno), .victoria(victoria)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       a, f, h, fin, vic;
      logic [2:0] barco;
      logic [3:0] celda;
   } res_t;

   res_t sb[$];
   int   total_chk = 0, bad_chk = 0;
   int   tab[5][5], disp[5][5], golpes[6];
   int   aciertos = 0, ult = 0, cx = 4, cy = 4;
   bit   ganado = 0;

   localparam logic [5:0] IZQ = 6'b000001, ARR = 6'b000010, ABA = 6'b000100,
                          DER = 6'b001000, DISP = 6'b010000, NUEVO = 6'b100000;

   task automatic chk(input string tag, input int obs, input int exp);
      total_chk++;
      if (obs !== exp) begin
         bad_chk++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int contar(input logic [4:0][4:0][3:0] m, input int val);
      int n = 0;
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            if (int'(m[y][x]) == val) n++;
      return n;
   endfunction

   function automatic int contar_modelo(input int val);
      int n = 0;
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            if (disp[y][x] == val) n++;
      return n;
   endfunction

   task automatic limpiar_modelo();
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++) disp[y][x] = 0;
      for (int k = 0; k < 6; k++) golpes[k] = 0;
      aciertos = 0; ult = 0; cx = 4; cy = 4; ganado = 0;
   endtask

   task automatic cargar_entrada();
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++) matriz_enemigo[y][x] = 4'(tab[y][x]);
   endtask

   // Called at a negedge; returns at the negedge after the sampling edge.
   task automatic pulsar(input logic [5:0] m);
      {nuevo_juego, disparar, derecha, abajo, arriba, izquierda} = m;
      @(negedge clk);
      {nuevo_juego, disparar, derecha, abajo, arriba, izquierda} = '0;
   endtask

   task automatic mover(input int tx, input int ty);
      while (cx < tx) begin pulsar(IZQ); cx++; end
      while (cx > tx) begin pulsar(DER); cx--; end
      while (cy < ty) begin pulsar(ARR); cy++; end
      while (cy > ty) begin pulsar(ABA); cy--; end
      chk("cursor_x", int'(posicion_x), tx);
      chk("cursor_y", int'(posicion_y), ty);
   endtask

   task automatic disparo();
      res_t e, r;
      int   v;
      e = '0;
      e.vic = ganado;
      e.barco = 3'(ult);
      if (!ganado && disp[cy][cx] == 0) begin
         v = tab[cy][cx];
         if (v >= 1 && v <= 5) begin
            disp[cy][cx] = 9;
            e.a = 1'b1;
            golpes[v]++;
            aciertos++;
            if (golpes[v] == v) begin e.h = 1'b1; ult = v; e.barco = 3'(v); end
            if (aciertos == 15) begin ganado = 1; e.vic = 1'b1; end
         end else begin
            disp[cy][cx] = 8;
            e.f = 1'b1;
            e.fin = 1'b1;
         end
      end
      e.celda = 4'(disp[cy][cx]);
      sb.push_back(e);
      pulsar(DISP);
      @(negedge clk);
      r = sb.pop_front();
      chk($sformatf("acierto(%0d,%0d)", cx, cy), int'(acierto), int'(r.a));
      chk($sformatf("fallo(%0d,%0d)", cx, cy), int'(fallo), int'(r.f));
      chk($sformatf("hundido(%0d,%0d)", cx, cy), int'(hundido), int'(r.h));
      chk($sformatf("fin_turno(%0d,%0d)", cx, cy), int'(fin_turno), int'(r.fin));
      chk($sformatf("barco_hundido(%0d,%0d)", cx, cy), int'(barco_hundido), int'(r.barco));
      chk($sformatf("victoria(%0d,%0d)", cx, cy), int'(victoria), int'(r.vic));
      chk($sformatf("celda(%0d,%0d)", cx, cy), int'(matriz_disparos[cy][cx]), int'(r.celda));
      @(negedge clk);
      chk("pulses_one_cycle", int'({acierto, fallo, hundido, fin_turno}), 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_x"}, int'(posicion_x), 4);
      chk({tag, "_y"}, int'(posicion_y), 4);
      chk({tag, "_pulses"}, int'({acierto, fallo, hundido, fin_turno}), 0);
      chk({tag, "_victoria"}, int'(victoria), 0);
      chk({tag, "_barco"}, int'(barco_hundido), 0);
      chk({tag, "_shot_cells"}, 25 - contar(matriz_disparos, 0), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++) tab[y][x] = 0;
      tab[4][4] = 1;
      for (int x = 0; x < 4; x++) tab[4][x] = 4;
      for (int x = 0; x < 5; x++) tab[3][x] = 5;
      for (int x = 0; x < 3; x++) tab[2][x] = 3;
      tab[1][0] = 2; tab[1][1] = 2;
      tab[0][4] = 7;
      limpiar_modelo();
      cargar_entrada();

      repeat (2) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      en_disparo = 1'b1;
      repeat (2) @(negedge clk);
      disparo();
      matriz_enemigo = '0;

      repeat (6) begin pulsar(DER); if (cx > 0) cx--; end
      chk("sat_derecha_x", int'(posicion_x), 0);
      pulsar(ARR | ABA);
      chk("arr_aba_y", int'(posicion_y), 4);
      pulsar(IZQ | DER);
      chk("izq_der_x", int'(posicion_x), 0);
      mover(4, 4);
      pulsar(IZQ);
      chk("sat_izquierda_x", int'(posicion_x), 4);

      mover(0, 0);
      disparo();
      disparo();
      mover(4, 0);
      disparo();

      mover(0, 2); disparo();
      mover(1, 2); disparo();
      mover(2, 2); disparo();

      mover(0, 1);
      en_disparo = 1'b0;
      repeat (3) @(negedge clk);
      en_disparo = 1'b1;
      @(negedge clk);
      disparo();
      chk("retained_hits", contar(matriz_disparos, 9), contar_modelo(9));
      chk("retained_misses", contar(matriz_disparos, 8), contar_modelo(8));

      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            if (tab[y][x] >= 1 && tab[y][x] <= 5 && disp[y][x] == 0) begin
               mover(x, y);
               disparo();
            end
      chk("victoria_level", int'(victoria), 1);
      pulsar(DER);
      pulsar(ABA);
      chk("ganado_x_frozen", int'(posicion_x), cx);
      chk("ganado_y_frozen", int'(posicion_y), cy);
      disparo();

      cargar_entrada();
      pulsar(NUEVO);
      limpiar_modelo();
      chk_reset("nuevo");

      repeat (2) @(negedge clk);
      disparar = 1'b1;
      @(negedge clk);
      disparar = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_reset("rst_eval");
      @(negedge clk);
      chk_reset("rst_hold");
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
      $finish;
   end

endmodule
